// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request-check helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes the access size for every legal load/store
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic store, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] merged_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word_i[{offset_i, 3'b000} +: 8];
    assign half_lane = word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, byte_lane};
            F3_H:    load_data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, half_lane};
            default: load_data_o = word_i;
        endcase
    end

    // Sub-word stores overlay the new lane onto the word read back from memory
    always_comb begin
        merged_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                merged_o = word_i;
                merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            F3_H: begin
                merged_o = word_i;
                merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-word stores via read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_en,
    output logic [XLEN-1:0]       mem_data_in,
    input  logic [XLEN-1:0]       mem_data_out
);

    localparam int unsigned AW = ADDR_WIDTH + 2;

    lsu_state_t      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;
    logic            req_ill;
    logic            req_mis;
    logic            unused_addr_hi;

    // Address bits above the memory range are dropped so accesses wrap
    assign unused_addr_hi = ^req_addr[XLEN-1:AW];

    assign req_ill = !is_legal(req_store, req_funct3);
    assign req_mis = !req_ill && is_misaligned(req_funct3, req_addr[1:0]);

    lsu_align #(.XLEN(XLEN)) u_align (
        .word_i      (mem_data_out),
        .offset_i    (addr_q[1:0]),
        .funct3_i    (funct3_q),
        .wdata_i     (data_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr[AW-1:0];
                    data_d   = req_wdata;
                    mis_d    = req_mis;
                    ill_d    = req_ill;
                    if (req_ill || req_mis) begin
                        state_d = RESP;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            RMW_READ: begin
                data_d  = merged;
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign mem_write_en    = (state_q == WRITE);
    assign resp_misaligned = mis_q && (state_q == RESP);
    assign resp_illegal    = ill_q && (state_q == RESP);
    assign resp_rdata      = rdata_q;
    assign mem_address     = addr_q[AW-1:2];
    assign mem_data_in     = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic [15:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;

    logic [7:0]  ref_mem [0:262143];
    logic [31:0] exp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int          o_lat, o_wr_cnt, o_wr_cyc, o_rv_w;
    logic [31:0] o_rd, o_wr_data;
    logic [15:0] o_wr_addr;
    logic        o_mis, o_ill;

    int          e_lat, e_wr_cnt, e_wr_cyc;
    logic        e_mis, e_ill;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal),
        .mem_address     (mem_address),
        .mem_write_en    (mem_write_en),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_write_en) mem[mem_address] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_address];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'({a[17:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Reference: byte-addressed memory, size from funct3, plain arithmetic extension
    task automatic model_apply(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        int size, b;
        logic legal;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
        b     = int'(a[17:0]);
        e_ill = !legal;
        e_mis = legal && ((b % size) != 0);
        e_wr_cnt = 0;
        e_wr_cyc = 0;
        if (e_ill || e_mis) begin
            e_lat = 1;
        end else if (!st) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[b+i];
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            exp_rdata = v;
            e_lat = 2;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[b+i] = wd[8*i +: 8];
            e_lat    = (size == 4) ? 2 : 3;
            e_wr_cnt = 1;
            e_wr_cyc = e_lat - 1;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        int b;
        b = int'({a[17:2], 2'b00});
        pre_we = 1'b1; pre_addr = a[17:2]; pre_data = w;
        for (int i = 0; i < 4; i++) ref_mem[b+i] = w[8*i +: 8];
        @(posedge clk);
        #1 pre_we = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request from an idle negedge and records what the unit did over 5 cycles
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        o_lat = 0; o_wr_cnt = 0; o_wr_cyc = 0; o_rv_w = 0;
        o_rd = 32'h0; o_wr_data = 32'h0; o_wr_addr = 16'h0; o_mis = 1'b0; o_ill = 1'b0;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_write_en) begin
                o_wr_cnt++; o_wr_cyc = k; o_wr_addr = mem_address; o_wr_data = mem_data_in;
            end
            if (resp_valid) begin
                o_rv_w++;
                if (o_lat == 0) begin
                    o_lat = k; o_rd = resp_rdata; o_mis = resp_misaligned; o_ill = resp_illegal;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_tests++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %b want 0", mem_write_en); end
        n_tests++; if ({resp_misaligned, resp_illegal} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {resp_misaligned, resp_illegal}); end
        n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_tests++; if (mem_address !== 16'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0", mem_address); end
        n_tests++; if (mem_data_in !== 32'h0) begin n_fail++; $display("FAIL reset_data_in: got %h want 0", mem_data_in); end
        exp_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_extend;
        preload(32'h10, 32'h8899AABB);
        model_apply(1'b0, 3'b000, 32'h11, 32'h0);
        run_req(1'b0, 3'b000, 32'h11, 32'h0);
        n_tests++; if (o_rd !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_sext: got %h want ffffffaa", o_rd); end
        n_tests++; if (o_lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", o_lat); end
        n_tests++; if (o_wr_cnt !== 0) begin n_fail++; $display("FAIL lb_no_write: got %0d writes want 0", o_wr_cnt); end
        model_apply(1'b0, 3'b100, 32'h13, 32'h0);
        run_req(1'b0, 3'b100, 32'h13, 32'h0);
        n_tests++; if (o_rd !== 32'h00000088) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000088", o_rd); end
        n_tests++; if (o_rv_w !== 1) begin n_fail++; $display("FAIL lbu_resp_width: got %0d want 1", o_rv_w); end
    endtask

    task automatic test_halfword;
        model_apply(1'b0, 3'b001, 32'h12, 32'h0);
        run_req(1'b0, 3'b001, 32'h12, 32'h0);
        n_tests++; if (o_rd !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_sext: got %h want ffff8899", o_rd); end
        model_apply(1'b0, 3'b101, 32'h10, 32'h0);
        run_req(1'b0, 3'b101, 32'h10, 32'h0);
        n_tests++; if (o_rd !== 32'h0000AABB) begin n_fail++; $display("FAIL lhu_zext: got %h want 0000aabb", o_rd); end
        model_apply(1'b0, 3'b001, 32'h11, 32'h0);
        run_req(1'b0, 3'b001, 32'h11, 32'h0);
        n_tests++; if (o_mis !== 1'b1 || o_ill !== 1'b0) begin n_fail++; $display("FAIL lh_misaligned_flags: got mis=%b ill=%b want mis=1 ill=0", o_mis, o_ill); end
        n_tests++; if (o_lat !== 1) begin n_fail++; $display("FAIL lh_misaligned_latency: got %0d want 1", o_lat); end
        n_tests++; if (o_wr_cnt !== 0) begin n_fail++; $display("FAIL lh_misaligned_write: got %0d writes want 0", o_wr_cnt); end
        n_tests++; if (o_rd !== 32'h0000AABB) begin n_fail++; $display("FAIL lh_misaligned_rdata_hold: got %h want 0000aabb", o_rd); end
    endtask

    task automatic test_subword_store;
        model_apply(1'b1, 3'b000, 32'h12, 32'h12345677);
        run_req(1'b1, 3'b000, 32'h12, 32'h12345677);
        n_tests++; if (o_wr_cnt !== 1 || o_wr_cyc !== 2) begin n_fail++; $display("FAIL sb_write_cycle: got cnt=%0d cyc=%0d want cnt=1 cyc=2", o_wr_cnt, o_wr_cyc); end
        n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", o_lat); end
        n_tests++; if (o_wr_addr !== 16'h4) begin n_fail++; $display("FAIL sb_address: got %h want 0004", o_wr_addr); end
        n_tests++; if (mem[4] !== 32'h8877AABB) begin n_fail++; $display("FAIL sb_mem_word: got %h want 8877aabb", mem[4]); end
        n_tests++; if (o_rd !== 32'h0000AABB) begin n_fail++; $display("FAIL sb_rdata_hold: got %h want 0000aabb", o_rd); end
        model_apply(1'b1, 3'b001, 32'h10, 32'h0000CAFE);
        run_req(1'b1, 3'b001, 32'h10, 32'h0000CAFE);
        n_tests++; if (mem[4] !== 32'h8877CAFE) begin n_fail++; $display("FAIL sh_mem_word: got %h want 8877cafe", mem[4]); end
        n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", o_lat); end
    endtask

    task automatic test_word_and_errors;
        model_apply(1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
        run_req(1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
        n_tests++; if (o_wr_cnt !== 1 || o_wr_cyc !== 1) begin n_fail++; $display("FAIL sw_write_cycle: got cnt=%0d cyc=%0d want cnt=1 cyc=1", o_wr_cnt, o_wr_cyc); end
        n_tests++; if (o_lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", o_lat); end
        n_tests++; if (mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem_word: got %h want deadbeef", mem[5]); end
        model_apply(1'b0, 3'b010, 32'h14, 32'h0);
        run_req(1'b0, 3'b010, 32'h14, 32'h0);
        n_tests++; if (o_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", o_rd); end
        model_apply(1'b0, 3'b010, 32'h16, 32'h0);
        run_req(1'b0, 3'b010, 32'h16, 32'h0);
        n_tests++; if (o_mis !== 1'b1 || o_lat !== 1) begin n_fail++; $display("FAIL lw_misaligned: got mis=%b lat=%0d want mis=1 lat=1", o_mis, o_lat); end
        model_apply(1'b0, 3'b011, 32'h14, 32'h0);
        run_req(1'b0, 3'b011, 32'h14, 32'h0);
        n_tests++; if (o_ill !== 1'b1 || o_mis !== 1'b0) begin n_fail++; $display("FAIL load_illegal_flags: got ill=%b mis=%b want ill=1 mis=0", o_ill, o_mis); end
        n_tests++; if (o_lat !== 1 || o_wr_cnt !== 0) begin n_fail++; $display("FAIL load_illegal_access: got lat=%0d writes=%0d want lat=1 writes=0", o_lat, o_wr_cnt); end
        n_tests++; if (o_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_illegal_rdata_hold: got %h want deadbeef", o_rd); end
    endtask

    task automatic test_back_to_back;
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'h0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            n_tests++; if (req_ready !== ((c % 3 == 0) && (c <= 6))) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", c, req_ready, ((c % 3 == 0) && (c <= 6))); end
            n_tests++; if (resp_valid !== (c % 3 == 2)) begin n_fail++; $display("FAIL b2b_resp_valid c%0d: got %b want %b", c, resp_valid, (c % 3 == 2)); end
            if (c % 3 == 2) begin
                n_tests++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rdata c%0d: got %h want deadbeef", c, resp_rdata); end
            end
            if (c == 0) req_valid = 1'b1;
            if (c == 7) req_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int bad_wr, bad_rv;
        bad_wr = 0; bad_rv = 0;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_rdata = 32'h0;
        n_tests++; if (mem_write_en !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL midop_reset_state: got we=%b ready=%b want we=0 ready=1", mem_write_en, req_ready); end
        n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL midop_reset_rdata: got %h want 0", resp_rdata); end
        repeat (2) begin
            @(negedge clk);
            if (mem_write_en) bad_wr++;
            if (resp_valid) bad_rv++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write_en) bad_wr++;
            if (resp_valid) bad_rv++;
        end
        n_tests++; if (bad_wr !== 0 || bad_rv !== 0) begin n_fail++; $display("FAIL midop_activity: got writes=%0d resps=%0d want 0 0", bad_wr, bad_rv); end
        n_tests++; if (mem[4] !== 32'h8877CAFE) begin n_fail++; $display("FAIL midop_mem_word: got %h want 8877cafe", mem[4]); end
        model_apply(1'b0, 3'b010, 32'h10, 32'h0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        n_tests++; if (o_rd !== 32'h8877CAFE || o_lat !== 2) begin n_fail++; $display("FAIL midop_reload: got %h lat=%0d want 8877cafe lat=2", o_rd, o_lat); end
    endtask

    task automatic test_random;
        logic        st, ill;
        logic [2:0]  f3;
        logic [31:0] a, wd, lo;
        for (int w = 0; w < 16; w++) preload(32'h100 + 32'(4*w), $urandom);
        for (int it = 0; it < 60; it++) begin
            st  = 1'($urandom);
            f3  = 3'($urandom);
            wd  = $urandom;
            ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
            lo  = 32'h100 + 32'($urandom_range(0, 63));
            if (ill) lo = lo & 32'hFFFF_FFFC;
            a   = ($urandom & 32'hFFFC_0000) | lo;
            model_apply(st, f3, a, wd);
            run_req(st, f3, a, wd);
            n_tests++; if (o_lat !== e_lat) begin n_fail++; $display("FAIL rnd%0d_latency st=%b f3=%0d a=%h: got %0d want %0d", it, st, f3, a, o_lat, e_lat); end
            n_tests++; if (o_wr_cnt !== e_wr_cnt || o_wr_cyc !== e_wr_cyc) begin n_fail++; $display("FAIL rnd%0d_write st=%b f3=%0d: got cnt=%0d cyc=%0d want cnt=%0d cyc=%0d", it, st, f3, o_wr_cnt, o_wr_cyc, e_wr_cnt, e_wr_cyc); end
            n_tests++; if (o_rv_w !== 1) begin n_fail++; $display("FAIL rnd%0d_resp_width: got %0d want 1", it, o_rv_w); end
            n_tests++; if (o_mis !== e_mis || o_ill !== e_ill) begin n_fail++; $display("FAIL rnd%0d_flags st=%b f3=%0d a=%h: got mis=%b ill=%b want mis=%b ill=%b", it, st, f3, a, o_mis, o_ill, e_mis, e_ill); end
            n_tests++; if (o_rd !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata st=%b f3=%0d a=%h: got %h want %h", it, st, f3, a, o_rd, exp_rdata); end
            n_tests++; if (mem[a[17:2]] !== ref_word(a)) begin n_fail++; $display("FAIL rnd%0d_mem a=%h: got %h want %h", it, a, mem[a[17:2]], ref_word(a)); end
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        pre_we = 1'b0; pre_addr = 16'h0; pre_data = 32'h0;
        exp_rdata = 32'h0;
        test_reset();
        test_load_extend();
        test_halfword();
        test_subword_store();
        test_word_and_errors();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
